// File: rtl/code_decoder.sv
// Decodes encoder codewords to {symbol, value}; 2-cycle latency code_in -> out_valid, FWFT FIFO of DEPTH entries.
// Backpressure via out_valid/out_ready; hits arriving at a full FIFO with no pop are dropped and flag overflow.
module code_decoder #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_sym,
    output logic             fifo_full,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] null_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [2:0]       sym;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic [WIDTH-1:0] code_q, code_d;
    logic             cap_v_q, cap_v_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, null_cnt_q, null_cnt_d, err_cnt_q, err_cnt_d;
    logic             err_flag_q, err_flag_d, overflow_q, overflow_d;

    logic             is_hit, is_null, is_err;
    logic [2:0]       dec_sym;
    logic [WIDTH-1:0] dec_data;
    logic             full, pop, push_ok;

    always_comb begin
        is_hit   = 1'b0;
        is_null  = 1'b0;
        is_err   = 1'b0;
        dec_sym  = 3'd0;
        dec_data = '0;
        if (cap_v_q) begin
            case (code_q)
                WIDTH'(32'h0000058F): begin is_hit = 1'b1; dec_sym = 3'd0; dec_data = WIDTH'(0);     end
                WIDTH'(32'hFFFFFA70): begin is_hit = 1'b1; dec_sym = 3'd1; dec_data = WIDTH'(123);   end
                WIDTH'(32'hFF807017): begin is_hit = 1'b1; dec_sym = 3'd2; dec_data = WIDTH'(1023);  end
                WIDTH'(32'h007B8FF7): begin is_hit = 1'b1; dec_sym = 3'd3; dec_data = WIDTH'(10023); end
                WIDTH'(32'hFFFFF05F): begin is_hit = 1'b1; dec_sym = 3'd4; dec_data = WIDTH'(7000);  end
                WIDTH'(32'h00000000): is_null = 1'b1;
                default:              is_err  = 1'b1;
            endcase
        end
    end

    assign full      = (occ_q == FULL_OCC);
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid && out_ready;
    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign push_ok   = is_hit && (!full || pop);

    always_comb begin
        code_d     = en ? code_in : code_q;
        cap_v_d    = en;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
        hit_cnt_d  = hit_cnt_q;
        null_cnt_d = null_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q || is_err;
        overflow_d = overflow_q || (is_hit && !push_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = '{sym: dec_sym, data: dec_data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (is_hit && hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
        if (is_null && null_cnt_q != '1) begin
            null_cnt_d = null_cnt_q + CNT_W'(1);
        end
        if (is_err && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q     <= '0;
            cap_v_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            hit_cnt_q  <= '0;
            null_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            code_q     <= code_d;
            cap_v_q    <= cap_v_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            hit_cnt_q  <= hit_cnt_d;
            null_cnt_q <= null_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: contents are only visible through the occupancy-gated head.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_data  = out_valid ? mem_q[rd_ptr_q].data : '0;
    assign out_sym   = out_valid ? mem_q[rd_ptr_q].sym  : 3'd0;
    assign fifo_full = full;
    assign hit_cnt   = hit_cnt_q;
    assign null_cnt  = null_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err_flag  = err_flag_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_code_decoder.sv
// Directed bench for code_decoder: table of per-cycle vectors plus hand-written FIFO/reset/enable sequences.
module tb_code_decoder;

    logic        clk, rst, en, out_ready;
    logic [31:0] code_in;
    logic        out_valid, fifo_full, err_flag, overflow;
    logic [31:0] out_data;
    logic [2:0]  out_sym;
    logic [15:0] hit_cnt, null_cnt, err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] C0 = 32'h0000058F;
    localparam logic [31:0] C1 = 32'hFFFFFA70;
    localparam logic [31:0] C2 = 32'hFF807017;
    localparam logic [31:0] C3 = 32'h007B8FF7;
    localparam logic [31:0] C4 = 32'hFFFFF05F;
    localparam logic [31:0] BAD = 32'h12345678;

    code_decoder #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .code_in(code_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sym(out_sym),
        .fifo_full(fifo_full), .hit_cnt(hit_cnt), .null_cnt(null_cnt), .err_cnt(err_cnt),
        .err_flag(err_flag), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        en;
        logic [31:0] code;
        logic        rdy;
        logic        v;
        logic [2:0]  sym;
        logic [31:0] data;
        int          hit;
        int          nul;
        int          err;
        logic        ef;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the negedge (like the encoder); outputs are then looked at 1ns after the posedge.
    task automatic step(input logic r, input logic e, input logic [31:0] c, input logic rd);
        @(negedge clk);
        rst       = r;
        en        = e;
        code_in   = c;
        out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_clear(input string tag);
        check({tag, " valid"},    32'(out_valid), 32'd0);
        check({tag, " sym"},      32'(out_sym),   32'd0);
        check({tag, " data"},     out_data,       32'd0);
        check({tag, " full"},     32'(fifo_full), 32'd0);
        check({tag, " hit_cnt"},  32'(hit_cnt),   32'd0);
        check({tag, " null_cnt"}, 32'(null_cnt),  32'd0);
        check({tag, " err_cnt"},  32'(err_cnt),   32'd0);
        check({tag, " err_flag"}, 32'(err_flag),  32'd0);
        check({tag, " overflow"}, 32'(overflow),  32'd0);
    endtask

    initial begin
        int pops;
        rst = 1'b0; en = 1'b0; code_in = '0; out_ready = 1'b0;

        //          en    code  rdy   v     sym   data       hit nul err ef
        vecs[0]  = '{1'b1, C0,  1'b1, 1'b0, 3'd0, 32'd0,     0,  0,  0, 1'b0};
        vecs[1]  = '{1'b1, C1,  1'b1, 1'b1, 3'd0, 32'd0,     1,  0,  0, 1'b0};
        vecs[2]  = '{1'b1, C2,  1'b1, 1'b1, 3'd1, 32'd123,   2,  0,  0, 1'b0};
        vecs[3]  = '{1'b1, C3,  1'b1, 1'b1, 3'd2, 32'd1023,  3,  0,  0, 1'b0};
        vecs[4]  = '{1'b1, C4,  1'b1, 1'b1, 3'd3, 32'd10023, 4,  0,  0, 1'b0};
        vecs[5]  = '{1'b0, 0,   1'b1, 1'b1, 3'd4, 32'd7000,  5,  0,  0, 1'b0};
        vecs[6]  = '{1'b0, 0,   1'b1, 1'b0, 3'd0, 32'd0,     5,  0,  0, 1'b0};
        vecs[7]  = '{1'b1, 0,   1'b1, 1'b0, 3'd0, 32'd0,     5,  0,  0, 1'b0};
        vecs[8]  = '{1'b1, BAD, 1'b1, 1'b0, 3'd0, 32'd0,     5,  1,  0, 1'b0};
        vecs[9]  = '{1'b1, C0,  1'b1, 1'b0, 3'd0, 32'd0,     5,  1,  1, 1'b1};
        vecs[10] = '{1'b0, 0,   1'b1, 1'b1, 3'd0, 32'd0,     6,  1,  1, 1'b1};
        vecs[11] = '{1'b0, 0,   1'b1, 1'b0, 3'd0, 32'd0,     6,  1,  1, 1'b1};

        // Reset with en/out_ready high: they must be ignored.
        step(1'b1, 1'b1, C3, 1'b1);
        check_clear("reset");

        // Legal stream, then null and illegal words, err_flag sticky past a later legal word.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, vecs[i].en, vecs[i].code, vecs[i].rdy);
            check($sformatf("v%0d valid", i), 32'(out_valid), 32'(vecs[i].v));
            check($sformatf("v%0d sym", i),   32'(out_sym),   32'(vecs[i].sym));
            check($sformatf("v%0d data", i),  out_data,       vecs[i].data);
            check($sformatf("v%0d hit", i),   32'(hit_cnt),   32'(vecs[i].hit));
            check($sformatf("v%0d null", i),  32'(null_cnt),  32'(vecs[i].nul));
            check($sformatf("v%0d err", i),   32'(err_cnt),   32'(vecs[i].err));
            check($sformatf("v%0d eflag", i), 32'(err_flag),  32'(vecs[i].ef));
            check($sformatf("v%0d ovf", i),   32'(overflow),  32'd0);
        end

        // Six hits with no consumer: fills after 4 pushes, then drops.
        step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b1, C0, 1'b0);
            if (i == 4) check("fill4 full", 32'(fifo_full), 32'd0);
            if (i == 5) begin
                check("fill5 full", 32'(fifo_full), 32'd1);
                check("fill5 ovf",  32'(overflow),  32'd0);
            end
        end
        step(1'b0, 1'b0, 0, 1'b0);
        check("fill hit_cnt", 32'(hit_cnt),   32'd6);
        check("fill ovf",     32'(overflow),  32'd1);
        check("fill full",    32'(fifo_full), 32'd1);
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                pops++;
                check("drain sym", 32'(out_sym), 32'd0);
            end
            step(1'b0, 1'b0, 0, 1'b1);
        end
        check("drain count", 32'(pops), 32'd4);

        // Full FIFO with simultaneous push and pop every cycle: no drop.
        step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, C4, 1'b0);
        check("steady pre full", 32'(fifo_full), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, C4, 1'b1);
            check("steady full", 32'(fifo_full), 32'd1);
            check("steady sym",  32'(out_sym),   32'd4);
            check("steady data", out_data,       32'd7000);
            check("steady ovf",  32'(overflow),  32'd0);
        end
        check("steady hit", 32'(hit_cnt), 32'd10);

        // Reset mid-stream: 3 buffered, one in stage 1, err_flag already set.
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, BAD, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, C1, 1'b0);
        check("pre-rst err",   32'(err_flag), 32'd1);
        check("pre-rst valid", 32'(out_valid), 32'd1);
        step(1'b1, 1'b1, C1, 1'b1);
        check_clear("midrst");
        step(1'b0, 1'b0, 0, 1'b1);
        check("post-rst valid", 32'(out_valid), 32'd0);
        check("post-rst hit",   32'(hit_cnt),   32'd0);

        // en toggling: only words sampled with en=1 are seen.
        step(1'b0, 1'b1, C2,  1'b1);
        step(1'b0, 1'b0, BAD, 1'b1);
        check("tog1 valid", 32'(out_valid), 32'd1);
        check("tog1 sym",   32'(out_sym),   32'd2);
        step(1'b0, 1'b1, C3, 1'b1);
        check("tog2 valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, 0, 1'b1);
        check("tog3 valid", 32'(out_valid), 32'd1);
        check("tog3 data",  out_data,       32'd10023);
        step(1'b0, 1'b0, 0, 1'b1);
        check("tog4 valid", 32'(out_valid), 32'd0);
        check("tog hit",    32'(hit_cnt),   32'd2);
        check("tog null",   32'(null_cnt),  32'd0);
        check("tog err",    32'(err_cnt),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/code_decoder.md
# code_decoder

Downstream consumer of the 32-bit codeword encoder stage. It samples the encoder's registered output on the rising clock edge, half a cycle after the encoder updates on the falling edge. It maps each of the five legal codewords back to its source value and symbol index, and buffers decoded results in a small first-word-fall-through FIFO with a valid/ready output handshake. Null and illegal codewords are counted, flagged and never forwarded.

## Interface
- WIDTH, 32, codeword and data width; the codebook is defined for 32 only.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- CNT_W, 16, width of the statistics counters.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset: synchronous, active-high.
- en  in  1  sample enable; code_in is captured on posedges where en=1.
- code_in  in  WIDTH  codeword from the encoder stage.
- out_valid  out  1  FIFO head holds a decoded entry.
- out_ready  in  1  consumer accepts the head.
- out_data  out  WIDTH  decoded source value at the FIFO head.
- out_sym  out  3  symbol index at the FIFO head (0..4).
- fifo_full  out  1  occupancy == DEPTH.
- hit_cnt  out  CNT_W  number of legal codewords decoded.
- null_cnt  out  CNT_W  number of 0x00000000 codewords.
- err_cnt  out  CNT_W  number of illegal codewords.
- err_flag  out  1  sticky; set on the first illegal codeword.
- overflow  out  1  sticky; set when a hit is dropped because the FIFO is full.

## Operation
Codebook: codeword -> symbol / out_data.
- 0x0000058F -> 0 / 0
- 0xFFFFFA70 -> 1 / 123
- 0xFF807017 -> 2 / 1023
- 0x007B8FF7 -> 3 / 10023
- 0xFFFFF05F -> 4 / 7000
- 0x00000000 -> null class: not pushed, null_cnt += 1.
- Any other value -> illegal: not pushed, err_cnt += 1, err_flag <= 1.

Stage 1 (capture):
- On posedge with en=1: code_q <= code_in, cap_v <= 1.
- On posedge with en=0: cap_v <= 0; code_q holds its value.

Stage 2 (classify and push), active when cap_v=1:
- code_q is classified combinationally.
- On a hit, hit_cnt += 1 and a push of {sym, data} is requested.

FIFO behaviour:
- Circular buffer with read/write pointers and an occupancy counter of log2(DEPTH)+1 bits.
- Pop occurs when out_valid && out_ready.
- Push when not full: accepted.
- Push when full with a pop in the same cycle: accepted; occupancy unchanged.
- Push when full without a pop: entry dropped, overflow <= 1. hit_cnt still increments.
- Pointers wrap modulo DEPTH.

Output and counter rules:
- out_data and out_sym always reflect the FIFO head.
- When the FIFO is empty, out_data and out_sym are 0.
- All counters saturate at 2^CNT_W-1 and never wrap.

Reset (rst=1 on a posedge):
- cap_v, code_q, the pointers, occupancy, all counters, err_flag and overflow are cleared.
- out_valid=0, out_sym=0, out_data=0, fifo_full=0.
- en and out_ready are ignored on the reset edge.
- Reset mid-stream discards buffered and in-flight entries; nothing is counted for the reset cycle.

## Timing
- code_in must be stable at the posedge. The encoder updates on the negedge, giving half a cycle of setup.
- Latency: code_in sampled at posedge N (en=1). It is classified and pushed at posedge N+1. out_valid=1 is visible after posedge N+1 if the FIFO was empty.
- Counters and flags also update at posedge N+1.
- Throughput: one codeword per cycle, sustained when out_ready=1.
- The handshake is registered only through FIFO state. out_valid does not depend combinationally on out_ready.
- Once asserted, out_valid stays high and the head stays stable until popped or reset.

## Test plan
- Reset, then en=1 feeding 0x0000058F, 0xFFFFFA70, 0xFF807017, 0x007B8FF7, 0xFFFFF05F with out_ready=1 -> out_valid first high after the 2nd posedge. Pairs come out in order: (0,0), (1,123), (2,1023), (3,10023), (4,7000). hit_cnt=5, null_cnt=0, err_cnt=0.
- Feed 0x00000000 then 0x12345678 -> no output. null_cnt=1, err_cnt=1, err_flag=1; err_flag stays 1 after subsequent legal words.
- out_ready=0 with six consecutive 0x0000058F -> fifo_full after the 4th push, overflow=1 on the 6th, hit_cnt=6. Draining yields exactly 4 entries.
- FIFO full with out_ready=1 while pushing 0xFFFFF05F every cycle -> no overflow, occupancy stays 4, sym 4 / 7000 continuously.
- Assert rst for one cycle with 3 entries buffered and a word in stage 1 -> the next cycle shows out_valid=0, all counters 0, and both flags 0.
- en toggling 1,0,1 with code_in changing every cycle -> only the words sampled with en=1 are decoded or counted.
